// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect
// and the decode-side handshake.
interface instr_fetch_stage_if #(
  parameter int N = 32
);
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [N-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [N-1:0] imem_rsp_data;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         id_ready;
  logic         if_valid;
  logic [N-1:0] if_instr;
  logic [N-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           branch_taken, branch_target, id_ready
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, one outstanding imem request, a small in-order
// instruction queue toward decode, and branch redirect with wrong-path squash.
//
// state   | meaning
// S_FETCH | no request in flight; may present a request when the queue has room
// S_WAIT  | one request accepted, waiting for its response word
module instr_fetch_stage #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           QDEPTH   = 2
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_stage_if.master bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

  typedef enum logic {S_FETCH, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  rsp_pc_q, rsp_pc_d;
  logic          outstanding_q, outstanding_d;
  logic          squash_q, squash_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  qpc_q    [QDEPTH];
  logic [N-1:0]  qinstr_q [QDEPTH];

  logic accept, rsp_take, push, pop, head_valid;

  assign head_valid = (count_q != '0);

  // Counting the in-flight request against free slots means a response can always be pushed.
  assign bus.imem_req_valid = !rst && (state_q == S_FETCH) &&
                              (({1'b0, count_q} + {{CW{1'b0}}, outstanding_q}) < QD);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = head_valid;
  assign bus.if_instr       = head_valid ? qinstr_q[head_q] : '0;
  assign bus.if_pc          = head_valid ? qpc_q[head_q] : '0;

  assign accept = bus.imem_req_valid && bus.imem_req_ready;

  always_comb begin
    rsp_take      = outstanding_q && bus.imem_rsp_valid;
    push          = rsp_take && !squash_q && !bus.branch_taken;
    pop           = head_valid && bus.id_ready && !bus.branch_taken;
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    squash_d      = squash_q;
    head_d        = pop  ? head_q + PW'(1) : head_q;
    tail_d        = push ? tail_q + PW'(1) : tail_q;
    count_d       = count_q + CW'(push) - CW'(pop);

    if (rsp_take) begin
      outstanding_d = 1'b0;
      squash_d      = 1'b0;
      state_d       = S_FETCH;
    end

    if (accept) begin
      pc_d          = pc_q + N'(4);
      rsp_pc_d      = pc_q;
      outstanding_d = 1'b1;
      state_d       = S_WAIT;
    end

    // A redirect keeps a request alive only if its response has not yet come back.
    if (bus.branch_taken) begin
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      pc_d          = bus.branch_target & ~N'(3);
      outstanding_d = (outstanding_q && !bus.imem_rsp_valid) || accept;
      squash_d      = outstanding_d;
      state_d       = outstanding_d ? S_WAIT : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= '0;
      outstanding_q <= 1'b0;
      squash_q      <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if (push) begin
        qpc_q[tail_q]    <= rsp_pc_q;
        qinstr_q[tail_q] <= bus.imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus a randomized run checked
// against a queue-based reference model of the fetch stage.
module tb_instr_fetch_stage;

  localparam int QDEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_stage_if #(.N(32)) bus ();

  instr_fetch_stage #(.N(32), .RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_squash;
  int          m_age;
  int          m_lat;
  int          lat_max = 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: advances by one clock using the inputs currently driven.
  task automatic model_step();
    bit   acc;
    ent_t e;
    if (rst) begin
      m_pc = 32'h0; m_q.delete(); m_out = 0; m_squash = 0; m_age = 0;
      return;
    end
    acc = !m_out && (m_q.size() < QDEPTH) && bus.imem_req_ready;
    if (bus.branch_taken) begin
      m_q.delete();
      m_out    = (m_out && bus.imem_rsp_valid !== 1'b1) || acc;
      m_squash = m_out;
      m_pc     = {bus.branch_target[31:2], 2'b00};
    end else begin
      if (m_q.size() > 0 && bus.id_ready) void'(m_q.pop_front());
      if (m_out && bus.imem_rsp_valid) begin
        if (!m_squash) begin
          e.pc = m_out_pc; e.instr = bus.imem_rsp_data; m_q.push_back(e);
        end
        m_out = 0; m_squash = 0;
      end
      if (acc) begin
        m_out_pc = m_pc; m_pc = m_pc + 32'd4; m_out = 1;
      end
    end
    if (acc) begin
      m_age = 0; m_lat = $urandom_range(1, lat_max);
    end else if (m_out) begin
      m_age++;
    end
  endtask

  // Drives one cycle of inputs; the memory answers the model's outstanding request.
  task automatic drive(input bit rdy, input bit idr, input bit br, input logic [31:0] tgt, input bit rsp_en);
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    bus.branch_taken   = br;
    bus.branch_target  = tgt;
    bus.imem_rsp_valid = rsp_en && m_out && (m_age + 1 >= m_lat);
    bus.imem_rsp_data  = mem(m_out_pc);
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lat_max = 1;
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 0, 32'h0, 0);
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid_in_rst: got %b expected 0", bus.imem_req_valid); end
    tick();
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid); end
    n_checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_data: got pc=%h instr=%h expected 0/0", bus.if_pc, bus.if_instr); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid_held: got %b expected 0", bus.imem_req_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h0, 1);
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_req%0d: got valid=%b addr=%h expected 1/%h", i, bus.imem_req_valid, bus.imem_req_addr, 32'(4 * i)); end
      if (i > 0) begin
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * (i - 1)) || bus.if_instr !== mem(32'(4 * (i - 1)))) begin n_fail++; $display("FAIL seq_if%0d: got v=%b pc=%h instr=%h expected 1/%h/%h", i, bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * (i - 1)), mem(32'(4 * (i - 1)))); end
      end
      tick();
      drive(1, 1, 0, 32'h0, 1);
      n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait%0d: got req_valid=%b expected 0", i, bus.imem_req_valid); end
      tick();
    end
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_instr !== mem(32'h8)) begin n_fail++; $display("FAIL seq_if_last: got v=%b pc=%h instr=%h expected 1/00000008/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem(32'h8)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 32'h0, 1);
      tick();
    end
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem(32'h0)) begin n_fail++; $display("FAIL bp_head0: got v=%b pc=%h instr=%h expected 1/00000000/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem(32'h0)); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_blocked: got %b expected 0", bus.imem_req_valid); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_instr !== mem(32'h4)) begin n_fail++; $display("FAIL bp_head1: got v=%b pc=%h instr=%h expected 1/00000004/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem(32'h4)); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume: got valid=%b addr=%h expected 1/00000008", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got if_valid=%b expected 0", bus.if_valid); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8) begin n_fail++; $display("FAIL bp_after: got v=%b pc=%h expected 1/00000008", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, (i < 4), 0, 32'h0, 1);
      tick();
    end
    drive(1, 0, 1, 32'h41, 0);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin n_fail++; $display("FAIL redir_pre_queue: got v=%b pc=%h expected 1/00000004", bus.if_valid, bus.if_pc); end
    tick();
    drive(1, 0, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got if_valid=%b expected 0", bus.if_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait_squash: got req_valid=%b expected 0", bus.imem_req_valid); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop_0x8: got if_valid=%b pc=%h expected 0", bus.if_valid, bus.if_pc); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin n_fail++; $display("FAIL redir_target_req: got valid=%b addr=%h expected 1/00000040", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_instr !== mem(32'h40)) begin n_fail++; $display("FAIL redir_first_if: got v=%b pc=%h instr=%h expected 1/00000040/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem(32'h40)); end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(1, 1, 1, 32'h100, 1);
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL brrsp_discard: got if_valid=%b expected 0", bus.if_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL brrsp_req: got valid=%b addr=%h expected 1/00000100", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== mem(32'h100)) begin n_fail++; $display("FAIL brrsp_no_stale_squash: got v=%b pc=%h expected 1/00000100", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'h0, 1);
      n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold%0d: got valid=%b addr=%h expected 1/00000000", i, bus.imem_req_valid, bus.imem_req_addr); end
      tick();
    end
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL stall_after: got v=%b pc=%h next_addr=%h expected 1/00000000/00000004", bus.if_valid, bus.if_pc, bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 1, 32'hFFFF_FFFF, 1);
    tick();
    drive(1, 1, 0, 32'h0, 1);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got valid=%b addr=%h expected 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    drive(0, 1, 0, 32'h0, 1);
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got valid=%b addr=%h expected 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_if_pc: got v=%b pc=%h expected 1/fffffffc", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 0, 32'h0, 1);
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    drive(0, 1, 0, 32'h0, 0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_if_valid: got %b expected 0", bus.if_valid); end
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc: got valid=%b addr=%h expected 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    drive(0, 1, 0, 32'h0, 0);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rsp: got if_valid=%b pc=%h instr=%h expected 0", bus.if_valid, bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_random();
    bit          exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_in;
    do_reset();
    lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), $urandom, 1);
      if (!m_out && $urandom_range(0, 7) == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = $urandom;
      end
      exp_v  = !rst && !m_out && (m_q.size() < QDEPTH);
      exp_pc = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
      exp_in = (m_q.size() > 0) ? m_q[0].instr : 32'h0;
      n_checks++; if (bus.imem_req_valid !== exp_v) begin n_fail++; $display("FAIL rnd_req_valid c%0d: got %b expected %b", c, bus.imem_req_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (bus.imem_req_addr !== m_pc) begin n_fail++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", c, bus.imem_req_addr, m_pc); end
      end
      n_checks++; if (bus.if_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_if_valid c%0d: got %b expected %b", c, bus.if_valid, (m_q.size() > 0)); end
      n_checks++; if (bus.if_pc !== exp_pc || bus.if_instr !== exp_in) begin n_fail++; $display("FAIL rnd_if_head c%0d: got pc=%h instr=%h expected %h/%h", c, bus.if_pc, bus.if_instr, exp_pc, exp_in); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = 32'h0;
    bus.id_ready       = 1'b0;
    m_pc = 32'h0; m_out_pc = 32'h0; m_out = 0; m_squash = 0; m_age = 0; m_lat = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_with_rsp();
    test_req_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
